// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the poly_rej_pack state type.
package dilithium_pkg;

  localparam int unsigned DIL_N          = 256;
  localparam int unsigned DIL_Q          = 8380417;
  localparam int unsigned DIL_COEF_W     = 32;
  localparam int unsigned DIL_POLY_BYTES = 768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/poly_rej_pack_if.sv
// Byte-stream interface for poly_rej_pack.
// Handshake: a byte transfers on a rising edge where out_valid and out_ready
// are both 1; while out_valid is high and out_ready is low, out_byte and
// out_last hold, and out_valid never depends on out_ready.
interface poly_rej_pack_if;

  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_byte, output out_valid, output out_last, input out_ready);
  modport slave  (input out_byte, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/poly_rej_pack_coef_byte_sel.sv
// coef_byte_sel: picks byte bi of a coefficient with bit 23 forced low.
// With POLY_PACK_RANGE_CHECK_EN defined it also flags coefficients that are
// negative or >= Q.
import dilithium_pkg::*;

module coef_byte_sel #(
  parameter int unsigned Q = DIL_Q
) (
  input  logic [DIL_COEF_W-1:0] coef,
  input  logic [1:0]            bi,
`ifdef POLY_PACK_RANGE_CHECK_EN
  output logic                  out_of_range,
`endif
  output logic [7:0]            byte_o
);

  // Byte select; the top byte keeps only bits 22:16 so the value stays < 2^23.
  always_comb begin
    byte_o = 8'h00;
    case (bi)
      2'd0:    byte_o = coef[7:0];
      2'd1:    byte_o = coef[15:8];
      2'd2:    byte_o = {1'b0, coef[22:16]};
      default: byte_o = 8'h00;
    endcase
  end

`ifdef POLY_PACK_RANGE_CHECK_EN
  assign out_of_range = coef[DIL_COEF_W-1] || (coef >= DIL_COEF_W'(Q));
`else
  // Upper bits and Q only matter to the range check.
  localparam logic [31:0] UNUSED_Q = 32'(Q);
  logic unused_hi;
  assign unused_hi = ^coef[DIL_COEF_W-1:23];
`endif

endmodule

// File: rtl/poly_rej_pack.sv
// poly_rej_pack: streams a 256-coefficient polynomial as 768 bytes, three
// little-endian bytes per coefficient with bit 23 cleared.
// Optional feature macro: POLY_PACK_RANGE_CHECK_EN (sticky err on coefficients
// that are negative or >= Q).
import dilithium_pkg::*;

module poly_rej_pack #(
  parameter int unsigned N      = DIL_N,
  parameter int unsigned COEF_W = DIL_COEF_W,
  parameter int unsigned Q      = DIL_Q
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N*COEF_W-1:0]   poly_in,
  poly_rej_pack_if.master       out_if,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output state_t                dbg_state
);

  localparam int CI_W = $clog2(N);
  localparam logic [CI_W-1:0] LAST_CI = CI_W'(N - 1);

  state_t              state_q, state_d;
  logic [CI_W-1:0]     ci_q, ci_d;
  logic [1:0]          bi_q, bi_d;
  logic [N*COEF_W-1:0] poly_q, poly_d;
  logic [DIL_COEF_W-1:0] cur_coef;
  logic [7:0]          sel_byte;
  logic                xfer;

  assign cur_coef = poly_q[ci_q*COEF_W +: DIL_COEF_W];
  assign xfer     = (state_q == SEND) && out_if.out_ready;

`ifdef POLY_PACK_RANGE_CHECK_EN
  logic oor;
  logic err_q, err_d;

  coef_byte_sel #(.Q(Q)) u_sel (
    .coef         (cur_coef),
    .bi           (bi_q),
    .out_of_range (oor),
    .byte_o       (sel_byte)
  );

  // Sticky range error: set on byte 0 of a bad coefficient, cleared on start.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start)
      err_d = 1'b0;
    else if (xfer && bi_q == 2'd0 && oor)
      err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  coef_byte_sel #(.Q(Q)) u_sel (
    .coef   (cur_coef),
    .bi     (bi_q),
    .byte_o (sel_byte)
  );

  assign err = 1'b0;
`endif

  // Next state, coefficient/byte indices and polynomial capture.
  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    bi_d    = bi_q;
    poly_d  = poly_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          poly_d  = poly_in;
          ci_d    = '0;
          bi_d    = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (bi_q == 2'd2) begin
            bi_d = 2'd0;
            ci_d = ci_q + CI_W'(1);
            if (ci_q == LAST_CI) state_d = DONE;
          end else begin
            bi_d = bi_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, index and polynomial registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ci_q    <= '0;
      bi_q    <= 2'd0;
      poly_q  <= '0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      bi_q    <= bi_d;
      poly_q  <= poly_d;
    end
  end

  assign out_if.out_valid = (state_q == SEND);
  assign out_if.out_byte  = (state_q == SEND) ? sel_byte : 8'h00;
  assign out_if.out_last  = (state_q == SEND) && (ci_q == LAST_CI) && (bi_q == 2'd2);
  assign busy             = (state_q == SEND) || (state_q == DONE);
  assign done             = (state_q == DONE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_poly_rej_pack.sv
// Testbench for poly_rej_pack: directed sequence with random coefficients and
// random out_ready stalls, checked against a byte-level reference model.
import dilithium_pkg::*;

module tb_poly_rej_pack;

  localparam int unsigned NB = DIL_POLY_BYTES;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic              start;
  logic [8191:0]     poly_in;
  logic              busy, done, err;
  state_t            dbg_state;

  poly_rej_pack_if out_if ();

  poly_rej_pack dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .poly_in   (poly_in),
    .out_if    (out_if),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] cur_c [256];
  bit          bad [256];
  logic [7:0]  got [768];
  logic        err_exp;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each coefficient gives its low three bytes, top byte limited to 7 bits.
  task automatic load_model();
    logic [31:0] c;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      c = cur_c[i];
      exp_q.push_back(8'(c & 32'hFF));
      exp_q.push_back(8'((c >> 8) & 32'hFF));
      exp_q.push_back(8'((c >> 16) & 32'h7F));
`ifdef POLY_PACK_RANGE_CHECK_EN
      bad[i] = ($signed(c) < 0) || (c >= 32'(DIL_Q));
`else
      bad[i] = 1'b0;
`endif
    end
    err_exp = 1'b0;
  endtask

  function automatic logic [8191:0] build_poly();
    logic [8191:0] p;
    for (int i = 0; i < 256; i++) p[32*i +: 32] = cur_c[i];
    return p;
  endfunction

  task automatic fill_random_valid();
    for (int i = 0; i < 256; i++) cur_c[i] = 32'($urandom_range(0, DIL_Q - 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_poly(input logic [8191:0] p);
    start   = 1'b1;
    poly_in = p;
    @(posedge clock);
    #1;
    start   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_if.out_valid), 32'd0);
    chk({tag, "_byte"},  32'(out_if.out_byte),  32'd0);
    chk({tag, "_last"},  32'(out_if.out_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),             32'd0);
    chk({tag, "_done"},  32'(done),             32'd0);
    chk({tag, "_err"},   32'(err),              32'd0);
    chk({tag, "_state"}, 32'(dbg_state),        32'(IDLE));
  endtask

  // Consumes one stream that has just been started; optional start pulse at
  // byte pulse_at and optional reset abort at byte abort_at.
  task automatic run_stream(input int low_pct, input int pulse_at,
                            input logic [8191:0] pulse_poly, input int abort_at);
    int         idx = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    bit         pulsed = 1'b0;
    logic [7:0] held = 8'h00;
    while (idx < NB && cyc < 4000) begin
      out_if.out_ready = ($urandom_range(0, 99) < low_pct) ? 1'b0 : 1'b1;
      if (idx == pulse_at && !pulsed) begin
        start = 1'b1; poly_in = pulse_poly; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (idx == abort_at) begin
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) begin
          @(negedge clock);
          chk("abort_no_done",  32'(done),             32'd0);
          chk("abort_no_valid", 32'(out_if.out_valid), 32'd0);
        end
        exp_q.delete();
        return;
      end
      @(negedge clock);
      chk("valid", 32'(out_if.out_valid), 32'd1);
      chk("byte",  32'(out_if.out_byte),  32'(exp_q[0]));
      chk("last",  32'(out_if.out_last),  32'(idx == NB - 1));
      chk("busy",  32'(busy),             32'd1);
      chk("done_early", 32'(done),        32'd0);
      chk("err",   32'(err),              32'(err_exp));
      if (stalled) chk("stall_hold", 32'(out_if.out_byte), 32'(held));
      if (out_if.out_ready) begin
        got[idx] = out_if.out_byte;
        if (idx % 3 == 0 && bad[idx / 3]) err_exp = 1'b1;
        void'(exp_q.pop_front());
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_if.out_byte;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    if (idx < NB) chk("timeout_bytes", 32'(idx), 32'(NB));
    if (low_pct == 0) chk("cycles", 32'(cyc), 32'(NB));
    @(negedge clock);
    chk("done_pulse", 32'(done),             32'd1);
    chk("done_valid", 32'(out_if.out_valid), 32'd0);
    chk("done_busy",  32'(busy),             32'd1);
    chk("done_err",   32'(err),              32'(err_exp));
    @(posedge clock); #1;
    @(negedge clock);
    chk("post_done",  32'(done),             32'd0);
    chk("post_busy",  32'(busy),             32'd0);
    chk("post_valid", 32'(out_if.out_valid), 32'd0);
    chk("post_err",   32'(err),              32'(err_exp));
  endtask

  // ---------------- directed sequence ----------------
  logic [8191:0] poly_a, poly_b;

  initial begin
    start            = 1'b0;
    poly_in          = '0;
    out_if.out_ready = 1'b0;
    reset            = 1'b0;
    #1;
    check_idle_outputs("reset");

    // start together with reset: reset wins
    start   = 1'b1;
    poly_in = '1;
    @(posedge clock); #1;
    chk("start_in_reset", 32'(out_if.out_valid), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle_after_reset", 32'(out_if.out_valid), 32'd0);

    // all-zero polynomial
    for (int i = 0; i < 256; i++) cur_c[i] = 32'd0;
    load_model();
    start_poly(build_poly());
    run_stream(0, -1, '0, -1);

    // known-answer: coef0 = Q-1, coef255 = 1
    for (int i = 0; i < 256; i++) cur_c[i] = 32'd0;
    cur_c[0]   = 32'(DIL_Q - 1);
    cur_c[255] = 32'd1;
    load_model();
    start_poly(build_poly());
    run_stream(0, -1, '0, -1);
    chk("kat_b0",   32'(got[0]),   32'h00);
    chk("kat_b1",   32'(got[1]),   32'hE0);
    chk("kat_b2",   32'(got[2]),   32'h7F);
    chk("kat_b765", 32'(got[765]), 32'h01);
    chk("kat_b766", 32'(got[766]), 32'h00);
    chk("kat_b767", 32'(got[767]), 32'h00);

    // random polynomial, unstalled then with 30% stalls
    fill_random_valid();
    poly_a = build_poly();
    load_model();
    start_poly(poly_a);
    run_stream(0, -1, '0, -1);
    load_model();
    start_poly(poly_a);
    run_stream(30, -1, '0, -1);

    // start pulse mid-stream is ignored; new polynomial used only on a fresh start
    fill_random_valid();
    poly_a = build_poly();
    load_model();
    fill_random_valid();
    poly_b = build_poly();
    start_poly(poly_a);
    run_stream(0, 100, poly_b, -1);
    repeat (3) begin
      @(negedge clock);
      chk("idle_no_restart", 32'(out_if.out_valid), 32'd0);
    end
    load_model();
    start_poly(poly_b);
    run_stream(0, -1, '0, -1);

    // out-of-range coefficients: Q at 5, -1 at 7
    fill_random_valid();
    cur_c[5] = 32'(DIL_Q);
    cur_c[7] = 32'hFFFF_FFFF;
    load_model();
    start_poly(build_poly());
    run_stream(0, -1, '0, -1);

    // fully random 32-bit values with stalls
    for (int i = 0; i < 256; i++) cur_c[i] = $urandom;
    load_model();
    start_poly(build_poly());
    run_stream(30, -1, '0, -1);

    // reset at byte 400, then restart from byte 0
    fill_random_valid();
    poly_a = build_poly();
    load_model();
    start_poly(poly_a);
    run_stream(0, -1, '0, 400);
    load_model();
    start_poly(poly_a);
    run_stream(0, -1, '0, -1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
